csm_mport_mem: RTL and testbench

// - N-port shared memory with hold/release locking; parametrised successor of the 2-processor (A/B) CSM.
// - Ports issue READ/WRITE/HOLD/RELEASE; a round-robin arbiter grants one request per cycle.
// - A held lock gives one port exclusive access; other ports' accesses fail with an error response.
// - Sits between N processor BFMs/requesters and the shared register file.

---
 rtl/csm_pkg.sv | 27 ++
 rtl/csm_rr_arbiter.sv | 59 +++++
 rtl/csm_mport_mem.sv | 174 +++++++++++++++++
 tb/tb_csm_mport_mem.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csm_pkg.sv
// -----------------------------------------------------------------------------
// csm_pkg
// Shared types and default sizes for the multi-port shared memory (CSM).
//   csm_cmd_e  : request command encoding carried on each port's 2-bit cmd lane
//   csm_lock_e : state of the hold/release lock
//   CSM_*      : default parameter values used by csm_mport_mem / csm_rr_arbiter
// -----------------------------------------------------------------------------
package csm_pkg;

    typedef enum logic [1:0] {
        CSM_READ    = 2'd0,
        CSM_WRITE   = 2'd1,
        CSM_HOLD    = 2'd2,
        CSM_RELEASE = 2'd3
    } csm_cmd_e;

    typedef enum logic {
        CSM_UNLOCKED = 1'b0,
        CSM_LOCKED   = 1'b1
    } csm_lock_e;

    localparam int CSM_NUM_PORTS    = 4;
    localparam int CSM_DATA_W       = 8;
    localparam int CSM_DEPTH        = 4;
    localparam int CSM_HOLD_TIMEOUT = 16;

endpackage

// File: rtl/csm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// csm_rr_arbiter
// Round-robin arbiter: picks at most one requester per cycle, starting the
// search at the pointer and wrapping modulo N. The pointer moves to the port
// after the winner; it stays put when nothing is granted.
// Ports:
//   i_clk        clock, rising edge
//   i_reset_n    asynchronous active-low reset (pointer -> 0)
//   i_req        per-port request
//   o_gnt        one-hot grant (combinational)
//   o_gnt_idx    index of the granted port (0 when none)
//   o_gnt_valid  a grant was issued this cycle
// -----------------------------------------------------------------------------
module csm_rr_arbiter
    import csm_pkg::*;
#(
    parameter  int N     = CSM_NUM_PORTS,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_valid
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_next_ptr;

    // Walk the ports from the pointer with explicit wrap, so non power-of-two
    // port counts never index past N-1; the first requester seen wins.
    always_comb begin
        o_gnt       = '0;
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        w_cand      = r_ptr;
        for (int i = 0; i < N; i++) begin
            if (!o_gnt_valid && i_req[w_cand]) begin
                o_gnt_valid   = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_gnt_idx     = w_cand;
            end
            w_cand = (w_cand == IDX_W'(N - 1)) ? '0 : w_cand + IDX_W'(1);
        end
    end

    assign w_next_ptr = (o_gnt_idx == IDX_W'(N - 1)) ? '0 : o_gnt_idx + IDX_W'(1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ptr <= '0;
        end else if (o_gnt_valid) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/csm_mport_mem.sv
// -----------------------------------------------------------------------------
// csm_mport_mem
// N-port shared register file with a hold/release lock. One request per cycle
// is granted round-robin; its response is registered and appears one cycle
// later on the granted port's rsp_valid bit. While a port holds the lock, any
// other port's request is answered with an error and has no effect.
// Optional feature macro: CSM_HOLD_TIMEOUT_EN -- a lock whose owner is not
// granted for HOLD_TIMEOUT cycles is force-released with a 1-cycle
// o_hold_timeout pulse. Without it the lock lasts until RELEASE or reset.
// Ports:
//   i_clk, i_reset_n      clock (rising edge), asynchronous active-low reset
//   i_req_valid/cmd/addr/wdata  per-port request lanes, packed port-major
//   o_req_ready           one-hot grant, combinational
//   o_rsp_valid           one-hot response, one cycle after grant
//   o_rsp_err             request refused (lock conflict or bad RELEASE)
//   o_rsp_rdata           read data for a successful READ, else 0
//   o_lock_valid          lock currently held
//   o_lock_owner          holding port, 0 when unlocked
//   o_hold_timeout        forced-release pulse (0 without the macro)
// -----------------------------------------------------------------------------
module csm_mport_mem
    import csm_pkg::*;
#(
    parameter  int NUM_PORTS    = CSM_NUM_PORTS,
    parameter  int DATA_W       = CSM_DATA_W,
    parameter  int DEPTH        = CSM_DEPTH,
    parameter  int HOLD_TIMEOUT = CSM_HOLD_TIMEOUT,
    localparam int ADDR_W       = $clog2(DEPTH),
    localparam int IDX_W        = $clog2(NUM_PORTS)
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [NUM_PORTS-1:0]        i_req_valid,
    input  logic [NUM_PORTS*2-1:0]      i_req_cmd,
    input  logic [NUM_PORTS*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] i_req_wdata,
    output logic [NUM_PORTS-1:0]        o_req_ready,
    output logic [NUM_PORTS-1:0]        o_rsp_valid,
    output logic                        o_rsp_err,
    output logic [DATA_W-1:0]           o_rsp_rdata,
    output logic                        o_lock_valid,
    output logic [IDX_W-1:0]            o_lock_owner,
    output logic                        o_hold_timeout
);

    logic [1:0]        w_cmd_arr   [NUM_PORTS];
    logic [ADDR_W-1:0] w_addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0] w_wdata_arr [NUM_PORTS];

    logic [NUM_PORTS-1:0] w_gnt;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic                 w_gnt_valid;
    csm_cmd_e             w_cmd;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_wdata;
    logic                 w_foreign;
    logic                 w_owner_gnt;

    logic [DATA_W-1:0]    r_mem [DEPTH];
    csm_lock_e            r_lock_state;
    logic [IDX_W-1:0]     r_lock_owner;
    logic [NUM_PORTS-1:0] r_rsp_valid;
    logic                 r_rsp_err;
    logic [DATA_W-1:0]    r_rsp_rdata;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign w_cmd_arr[p]   = i_req_cmd[p*2 +: 2];
        assign w_addr_arr[p]  = i_req_addr[p*ADDR_W +: ADDR_W];
        assign w_wdata_arr[p] = i_req_wdata[p*DATA_W +: DATA_W];
    end

    csm_rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_req       (i_req_valid),
        .o_gnt       (w_gnt),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_valid (w_gnt_valid)
    );

    assign w_cmd       = csm_cmd_e'(w_cmd_arr[w_gnt_idx]);
    assign w_addr      = w_addr_arr[w_gnt_idx];
    assign w_wdata     = w_wdata_arr[w_gnt_idx];
    // A granted port that is not the lock holder while the lock stands.
    assign w_foreign   = (r_lock_state == CSM_LOCKED) && (w_gnt_idx != r_lock_owner);
    assign w_owner_gnt = w_gnt_valid && (r_lock_state == CSM_LOCKED) && (w_gnt_idx == r_lock_owner);

`ifdef CSM_HOLD_TIMEOUT_EN
    localparam int TO_W = $clog2(HOLD_TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_hold_timeout;
    assign o_hold_timeout = r_hold_timeout;
`else
    assign o_hold_timeout = 1'b0;
`endif

    // Lock FSM, memory and response register share one process: the granted
    // command is executed against the lock state seen in the grant cycle.
    // A forced release only fires when the owner is not granted that cycle,
    // so an owner's command always sees its lock intact.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lock_state <= CSM_UNLOCKED;
            r_lock_owner <= '0;
            r_rsp_valid  <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
`ifdef CSM_HOLD_TIMEOUT_EN
            r_to_cnt       <= '0;
            r_hold_timeout <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= w_gnt;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef CSM_HOLD_TIMEOUT_EN
            r_hold_timeout <= 1'b0;
            if (r_lock_state == CSM_LOCKED) begin
                if (w_owner_gnt) begin
                    r_to_cnt <= '0;
                end else if (r_to_cnt == TO_W'(HOLD_TIMEOUT - 1)) begin
                    r_to_cnt       <= '0;
                    r_lock_state   <= CSM_UNLOCKED;
                    r_lock_owner   <= '0;
                    r_hold_timeout <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
`endif
            if (w_gnt_valid) begin
                unique case (w_cmd)
                    CSM_READ: begin
                        if (w_foreign) r_rsp_err <= 1'b1;
                        else           r_rsp_rdata <= r_mem[w_addr];
                    end
                    CSM_WRITE: begin
                        if (w_foreign) r_rsp_err <= 1'b1;
                        else           r_mem[w_addr] <= w_wdata;
                    end
                    CSM_HOLD: begin
                        if (w_foreign) begin
                            r_rsp_err <= 1'b1;
                        end else if (r_lock_state == CSM_UNLOCKED) begin
                            r_lock_state <= CSM_LOCKED;
                            r_lock_owner <= w_gnt_idx;
                        end
                    end
                    CSM_RELEASE: begin
                        if (w_foreign || (r_lock_state == CSM_UNLOCKED)) begin
                            r_rsp_err <= 1'b1;
                        end else begin
                            r_lock_state <= CSM_UNLOCKED;
                            r_lock_owner <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign o_req_ready  = w_gnt;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_err    = r_rsp_err;
    assign o_rsp_rdata  = r_rsp_rdata;
    assign o_lock_valid = (r_lock_state == CSM_LOCKED);
    assign o_lock_owner = r_lock_owner;

endmodule

// File: tb/tb_csm_mport_mem.sv
// -----------------------------------------------------------------------------
// tb_csm_mport_mem
// Scoreboard bench for csm_mport_mem: a behavioural model predicts each grant
// and queues the expected response, which is popped and compared on the
// following cycle. Directed scenarios add fixed expected values on top.
// -----------------------------------------------------------------------------
module tb_csm_mport_mem;
    import csm_pkg::*;

    localparam int NP    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int IW    = 2;
    localparam int HT    = 16;

    logic             clk = 1'b0;
    logic             rstN;
    logic [NP-1:0]    reqValid;
    logic [NP*2-1:0]  reqCmd;
    logic [NP*AW-1:0] reqAddr;
    logic [NP*DW-1:0] reqWdata;
    logic [NP-1:0]    reqReady;
    logic [NP-1:0]    rspValid;
    logic             rspErr;
    logic [DW-1:0]    rspRdata;
    logic             lockValid;
    logic [IW-1:0]    lockOwner;
    logic             holdTimeout;

    always #5 clk = ~clk;

    csm_mport_mem #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH), .HOLD_TIMEOUT(HT)) dut (
        .i_clk          (clk),
        .i_reset_n      (rstN),
        .i_req_valid    (reqValid),
        .i_req_cmd      (reqCmd),
        .i_req_addr     (reqAddr),
        .i_req_wdata    (reqWdata),
        .o_req_ready    (reqReady),
        .o_rsp_valid    (rspValid),
        .o_rsp_err      (rspErr),
        .o_rsp_rdata    (rspRdata),
        .o_lock_valid   (lockValid),
        .o_lock_owner   (lockOwner),
        .o_hold_timeout (holdTimeout)
    );

    typedef struct packed {
        logic [IW-1:0] port;
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    rsp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    // pending requests per port, held until the model grants them
    logic          pValid [NP];
    csm_cmd_e      pCmd   [NP];
    logic [AW-1:0] pAddr  [NP];
    logic [DW-1:0] pData  [NP];

    // reference model state
    logic [DW-1:0] mMem [DEPTH];
    logic          mLocked;
    int            mOwner;
    int            mPtr;
    int            mCnt;
    logic          mPulse;

    logic          lastErr;
    logic [DW-1:0] lastRdata;
    int            lastGrant;
    logic          sawPulse;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic driveInputs();
        for (int p = 0; p < NP; p++) begin
            reqValid[p]           = pValid[p];
            reqCmd[p*2 +: 2]      = pCmd[p];
            reqAddr[p*AW +: AW]   = pAddr[p];
            reqWdata[p*DW +: DW]  = pData[p];
        end
    endtask

    task automatic applyStimulus(input int port, input csm_cmd_e cmd, input int addr, input int data);
        pValid[port] = 1'b1;
        pCmd[port]   = cmd;
        pAddr[port]  = AW'(addr);
        pData[port]  = DW'(data);
        driveInputs();
    endtask

    function automatic int pendingCount();
        int n = 0;
        for (int p = 0; p < NP; p++) if (pValid[p]) n++;
        return n;
    endfunction

    task automatic applyReset();
        rstN = 1'b0;
        for (int p = 0; p < NP; p++) begin
            pValid[p] = 1'b0;
            pCmd[p]   = CSM_READ;
            pAddr[p]  = '0;
            pData[p]  = '0;
        end
        driveInputs();
        #2;
        checkOutput("rstRspValid", 32'(rspValid), 32'd0);
        checkOutput("rstRspErr", 32'(rspErr), 32'd0);
        checkOutput("rstRspRdata", 32'(rspRdata), 32'd0);
        checkOutput("rstLockValid", 32'(lockValid), 32'd0);
        checkOutput("rstLockOwner", 32'(lockOwner), 32'd0);
        checkOutput("rstHoldTimeout", 32'(holdTimeout), 32'd0);
        expQ.delete();
        for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
        mLocked = 1'b0;
        mOwner  = 0;
        mPtr    = 0;
        mCnt    = 0;
        mPulse  = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: check last cycle's response and current grant at the
    // falling edge, advance the model, then retire the granted request.
    task automatic step();
        rsp_t          e;
        rsp_t          pushE;
        int            g;
        logic [NP-1:0] expReady;
        logic          err;
        logic [DW-1:0] rd;
        logic          foreign;
        logic          timeoutNow;
        @(negedge clk);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            expReady = '0;
            expReady[e.port] = 1'b1;
            checkOutput("rspValid", 32'(rspValid), 32'(expReady));
            checkOutput("rspErr", 32'(rspErr), 32'(e.err));
            checkOutput("rspRdata", 32'(rspRdata), 32'(e.rdata));
            lastErr   = rspErr;
            lastRdata = rspRdata;
        end else begin
            checkOutput("rspIdle", 32'(rspValid), 32'd0);
        end
        checkOutput("lockValid", 32'(lockValid), 32'(mLocked));
        checkOutput("lockOwner", 32'(lockOwner), mLocked ? 32'(mOwner) : 32'd0);
        checkOutput("holdTimeout", 32'(holdTimeout), 32'(mPulse));
        if (holdTimeout === 1'b1) sawPulse = 1'b1;

        g = -1;
        for (int i = 0; i < NP; i++) begin
            int c;
            c = (mPtr + i) % NP;
            if (g < 0 && pValid[c]) g = c;
        end
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        checkOutput("reqReady", 32'(reqReady), 32'(expReady));
        lastGrant = g;

        mPulse     = 1'b0;
        timeoutNow = 1'b0;
`ifdef CSM_HOLD_TIMEOUT_EN
        if (mLocked) begin
            if (g == mOwner) mCnt = 0;
            else if (mCnt == HT - 1) begin
                mCnt       = 0;
                timeoutNow = 1'b1;
            end else mCnt++;
        end else begin
            mCnt = 0;
        end
`endif
        if (g >= 0) begin
            err     = 1'b0;
            rd      = '0;
            foreign = mLocked && (g != mOwner);
            case (pCmd[g])
                CSM_READ:    if (foreign) err = 1'b1; else rd = mMem[pAddr[g]];
                CSM_WRITE:   if (foreign) err = 1'b1; else mMem[pAddr[g]] = pData[g];
                CSM_HOLD:    if (foreign) err = 1'b1;
                             else if (!mLocked) begin mLocked = 1'b1; mOwner = g; end
                CSM_RELEASE: if (!mLocked || foreign) err = 1'b1;
                             else begin mLocked = 1'b0; mOwner = 0; end
            endcase
            pushE.port  = IW'(g);
            pushE.err   = err;
            pushE.rdata = rd;
            expQ.push_back(pushE);
            mPtr = (g + 1) % NP;
        end
        if (timeoutNow) begin
            mLocked = 1'b0;
            mOwner  = 0;
            mPulse  = 1'b1;
        end
        @(posedge clk);
        #1;
        if (g >= 0) pValid[g] = 1'b0;
        driveInputs();
    endtask

    task automatic drain();
        int n = 0;
        while ((pendingCount() > 0 || expQ.size() > 0) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) checkOutput("drainBudget", 32'(pendingCount() + expQ.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int       rrExp [5];
        int       n;
        int       r;
        csm_cmd_e cmd;
        rrExp    = '{0, 1, 2, 3, 0};
        sawPulse = 1'b0;
        applyReset();

        $display("[TB] write then read");
        applyStimulus(0, CSM_WRITE, 2, 'hA5); drain();
        checkOutput("wrErr", 32'(lastErr), 32'd0);
        applyStimulus(1, CSM_READ, 2, 0); drain();
        checkOutput("rdA5", 32'(lastRdata), 32'hA5);
        checkOutput("rdA5Err", 32'(lastErr), 32'd0);

        $display("[TB] hold and release");
        applyStimulus(0, CSM_WRITE, 0, 'h11); drain();
        applyStimulus(0, CSM_HOLD, 0, 0); drain();
        checkOutput("holdLock", 32'(lockValid), 32'd1);
        applyStimulus(1, CSM_WRITE, 0, 'h3C); drain();
        checkOutput("foreignWrErr", 32'(lastErr), 32'd1);
        applyStimulus(1, CSM_READ, 0, 0); drain();
        checkOutput("foreignRdErr", 32'(lastErr), 32'd1);
        checkOutput("foreignRdData", 32'(lastRdata), 32'd0);
        applyStimulus(0, CSM_READ, 2, 0); drain();
        checkOutput("ownerRd", 32'(lastRdata), 32'hA5);
        applyStimulus(0, CSM_RELEASE, 0, 0); drain();
        checkOutput("releaseErr", 32'(lastErr), 32'd0);
        applyStimulus(1, CSM_READ, 0, 0); drain();
        checkOutput("afterRelErr", 32'(lastErr), 32'd0);
        checkOutput("afterRelData", 32'(lastRdata), 32'h11);

        $display("[TB] round robin");
        applyReset();
        for (int c = 0; c < 5; c++) begin
            for (int p = 0; p < NP; p++) if (!pValid[p]) applyStimulus(p, CSM_READ, p, 0);
            step();
            checkOutput("rrOrder", 32'(lastGrant), 32'(rrExp[c]));
        end
        for (int p = 0; p < NP; p++) pValid[p] = 1'b0;
        driveInputs();
        drain();

        $display("[TB] simultaneous holds");
        applyReset();
        applyStimulus(1, CSM_HOLD, 0, 0);
        applyStimulus(2, CSM_HOLD, 0, 0);
        step();
        checkOutput("simulGrant", 32'(lastGrant), 32'd1);
        step();
        checkOutput("p1HoldErr", 32'(lastErr), 32'd0);
        checkOutput("ownerIs1", 32'(lockOwner), 32'd1);
        drain();
        checkOutput("p2HoldErr", 32'(lastErr), 32'd1);
        applyStimulus(1, CSM_HOLD, 0, 0); drain();
        checkOutput("reHold1Err", 32'(lastErr), 32'd0);
        applyStimulus(1, CSM_HOLD, 0, 0); drain();
        checkOutput("reHold2Err", 32'(lastErr), 32'd0);
        checkOutput("reHoldOwner", 32'(lockOwner), 32'd1);
        applyStimulus(1, CSM_RELEASE, 0, 0); drain();
        applyStimulus(3, CSM_RELEASE, 0, 0); drain();
        checkOutput("relUnlockedErr", 32'(lastErr), 32'd1);

        $display("[TB] repeated write");
        applyStimulus(2, CSM_WRITE, 1, 'h5A); drain();
        checkOutput("wr1Err", 32'(lastErr), 32'd0);
        applyStimulus(2, CSM_WRITE, 1, 'h5A); drain();
        checkOutput("wr2Err", 32'(lastErr), 32'd0);
        applyStimulus(3, CSM_READ, 1, 0); drain();
        checkOutput("rd5A", 32'(lastRdata), 32'h5A);

        $display("[TB] random traffic");
        for (int c = 0; c < 60; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pValid[p] && $urandom_range(0, 2) == 0) begin
                    r = int'($urandom_range(0, 9));
                    cmd = (r < 4) ? CSM_READ : (r < 8) ? CSM_WRITE : (r == 8) ? CSM_HOLD : CSM_RELEASE;
                    applyStimulus(p, cmd, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)));
                end
            end
            step();
        end
        drain();

        $display("[TB] reset mid-lock");
        applyReset();
        applyStimulus(0, CSM_WRITE, 3, 'h77); drain();
        applyStimulus(2, CSM_HOLD, 0, 0); drain();
        applyStimulus(2, CSM_READ, 3, 0);
        step();
        applyReset();
        applyStimulus(0, CSM_READ, 3, 0); drain();
        checkOutput("rstMemErr", 32'(lastErr), 32'd0);
        checkOutput("rstMemData", 32'(lastRdata), 32'd0);

        $display("[TB] stale hold");
        applyStimulus(2, CSM_HOLD, 0, 0); drain();
        sawPulse = 1'b0;
        n = 0;
`ifdef CSM_HOLD_TIMEOUT_EN
        while (!sawPulse && n < 40) begin
            step();
            n++;
        end
        checkOutput("timeoutDelay", 32'(n), 32'd16);
        checkOutput("timeoutUnlock", 32'(lockValid), 32'd0);
`else
        while (n < 20) begin
            step();
            n++;
        end
        checkOutput("holdPersists", 32'(lockValid), 32'd1);
        checkOutput("noPulse", 32'(sawPulse), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
